// File: rtl/stimulus_sp.sv
// -----------------------------------------------------------------------------
// stimulus_sp
//
// Registered stimulus generator for the single-port BRAM simulation harness.
// A start pulse launches a fixed phase sequence that drives the BRAM wrapper
// ports (and, in parallel, the single-port read-data checker):
//
//   FILL -> READ -> RMW -> VERIFY -> RANDOM -> RSTP -> DRAIN -> DONE
//
// Every output is registered. The internal logic is active-high, and each
// control output is converted to the BRAM's active level at the register
// input (logical value XNOR its *_POLARITY).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   launch the sequence (sampled only in IDLE or DONE)
//   busy      out  high from the first stimulus cycle through drain
//   done      out  high in DONE until the next start
//   bram_rst  out  BRAM reset, at RST_POLARITY
//   wclke     out  write clock enable, at WCLKE_POLARITY
//   we        out  write enable, at WE_POLARITY
//   re        out  read enable, at RE_POLARITY
//   addr      out  address
//   byteen    out  byte enables, each bit at BYTEEN_POLARITY
//   wdata_a   out  write data
//   addren    out  address enable (Titanium only; tied active on Trion)
// -----------------------------------------------------------------------------
module stimulus_sp #(
    parameter int          DATA_WIDTH_A    = 16,
    parameter int          ADDR_WIDTH_A    = 4,
    parameter int          BYTEEN_WIDTH    = 2,
    parameter logic        WE_POLARITY     = 1'b1,
    parameter logic        RE_POLARITY     = 1'b1,
    parameter logic        WCLKE_POLARITY  = 1'b1,
    parameter logic        BYTEEN_POLARITY = 1'b1,
    parameter logic        ADDREN_POLARITY = 1'b1,
    parameter logic        RST_POLARITY    = 1'b1,
    parameter string       FAMILY          = "TITANIUM",
    parameter int          NUM_RANDOM      = 64,
    parameter int          RST_CYCLES      = 2,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_1234
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    bram_rst,
    output logic                    wclke,
    output logic                    we,
    output logic                    re,
    output logic [ADDR_WIDTH_A-1:0] addr,
    output logic [BYTEEN_WIDTH-1:0] byteen,
    output logic [DATA_WIDTH_A-1:0] wdata_a,
    output logic                    addren
);

    localparam int  DEPTH    = 2 ** ADDR_WIDTH_A;
    localparam int  ACW      = ADDR_WIDTH_A + 1;
    localparam int  DRAIN_N  = 3;
    localparam int  OCNT_MAX = (NUM_RANDOM > RST_CYCLES)
                             ? ((NUM_RANDOM > DRAIN_N) ? NUM_RANDOM : DRAIN_N)
                             : ((RST_CYCLES > DRAIN_N) ? RST_CYCLES : DRAIN_N);
    localparam int  OCNT_W   = $clog2(OCNT_MAX);
    localparam bit  IS_TRION = (FAMILY == "TRION");

    // Galois form of x^32 + x^22 + x^2 + x + 1 for a right-shifting register.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [ACW-1:0]    ACNT_LAST  = ACW'(DEPTH - 1);
    localparam logic [OCNT_W-1:0] RAND_LAST  = OCNT_W'(NUM_RANDOM - 1);
    localparam logic [OCNT_W-1:0] RSTP_LAST  = OCNT_W'(RST_CYCLES - 1);
    localparam logic [OCNT_W-1:0] DRAIN_LAST = OCNT_W'(DRAIN_N - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_RMW,
        S_VERIFY,
        S_RANDOM,
        S_RSTP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ACW-1:0]      acnt_q, acnt_d;   // address-phase counter
    logic [OCNT_W-1:0]   ocnt_q, ocnt_d;   // random / reset / drain counter
    logic [31:0]         lfsr_q, lfsr_d;

    // Logical (active-high) values to be registered onto the outputs.
    logic                    nx_busy;
    logic                    nx_done;
    logic                    nx_bram_rst;
    logic                    nx_wclke;
    logic                    nx_we;
    logic                    nx_re;
    logic                    nx_addren;
    logic [ADDR_WIDTH_A-1:0] nx_addr;
    logic [BYTEEN_WIDTH-1:0] nx_byteen;
    logic [DATA_WIDTH_A-1:0] nx_wdata;
    logic [ADDR_WIDTH_A-1:0] a_d;

    // Address replicated across the data word, truncated to DATA_WIDTH_A.
    function automatic logic [DATA_WIDTH_A-1:0] fill_word(input logic [ADDR_WIDTH_A-1:0] a);
        logic [DATA_WIDTH_A-1:0] w;
        for (int i = 0; i < DATA_WIDTH_A; i++) begin
            w[i] = a[i % ADDR_WIDTH_A];
        end
        return w;
    endfunction

    // Upper LFSR half replicated across the data word, truncated.
    function automatic logic [DATA_WIDTH_A-1:0] rand_word(input logic [15:0] h);
        logic [DATA_WIDTH_A-1:0] w;
        for (int i = 0; i < DATA_WIDTH_A; i++) begin
            w[i] = h[i % 16];
        end
        return w;
    endfunction

    // One-hot byte enable selecting group (a mod BYTEEN_WIDTH).
    function automatic logic [BYTEEN_WIDTH-1:0] lane_onehot(input logic [ADDR_WIDTH_A-1:0] a);
        logic [BYTEEN_WIDTH-1:0] b;
        for (int i = 0; i < BYTEEN_WIDTH; i++) begin
            b[i] = ((int'(a) % BYTEEN_WIDTH) == i);
        end
        return b;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        acnt_d  = acnt_q;
        ocnt_d  = ocnt_q;
        lfsr_d  = lfsr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FILL;
                    acnt_d  = '0;
                    ocnt_d  = '0;
                    lfsr_d  = LFSR_SEED;
                end
            end
            S_FILL, S_READ, S_RMW, S_VERIFY: begin
                if (acnt_q == ACNT_LAST) begin
                    acnt_d = '0;
                    ocnt_d = '0;
                    case (state_q)
                        S_FILL:  state_d = S_READ;
                        S_READ:  state_d = S_RMW;
                        S_RMW:   state_d = S_VERIFY;
                        default: state_d = S_RANDOM;
                    endcase
                end else begin
                    acnt_d = acnt_q + 1'b1;
                end
            end
            S_RANDOM: begin
                if (ocnt_q == RAND_LAST) begin
                    state_d = S_RSTP;
                    ocnt_d  = '0;
                end else begin
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
            S_RSTP: begin
                if (ocnt_q == RSTP_LAST) begin
                    state_d = S_DRAIN;
                    ocnt_d  = '0;
                end else begin
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (ocnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    ocnt_d  = '0;
                end else begin
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The outputs of a RANDOM cycle use the current LFSR value; the register
        // advances in the same cycle so the next RANDOM cycle sees the next value.
        if (state_d == S_RANDOM) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Decoded from the *next* state so the registered outputs
    // line up with the state being entered (first stimulus one edge after the
    // edge that samples start).
    // -------------------------------------------------------------------------
    assign a_d = acnt_d[ADDR_WIDTH_A-1:0];

    always_comb begin
        nx_busy     = 1'b0;
        nx_done     = 1'b0;
        nx_bram_rst = 1'b0;
        nx_wclke    = 1'b0;
        nx_we       = 1'b0;
        nx_re       = 1'b0;
        nx_addren   = 1'b0;
        nx_addr     = '0;
        nx_byteen   = '0;
        nx_wdata    = '0;

        case (state_d)
            S_FILL: begin
                nx_busy   = 1'b1;
                nx_wclke  = 1'b1;
                nx_we     = 1'b1;
                nx_addren = 1'b1;
                nx_addr   = a_d;
                nx_byteen = '1;
                nx_wdata  = fill_word(a_d);
            end
            S_READ, S_VERIFY: begin
                nx_busy   = 1'b1;
                nx_re     = 1'b1;
                nx_addren = 1'b1;
                nx_addr   = a_d;
            end
            S_RMW: begin
                // Same-cycle read and write of one byte lane exercises the
                // BRAM's read-during-write behaviour.
                nx_busy   = 1'b1;
                nx_wclke  = 1'b1;
                nx_we     = 1'b1;
                nx_re     = 1'b1;
                nx_addren = 1'b1;
                nx_addr   = a_d;
                nx_byteen = lane_onehot(a_d);
                nx_wdata  = ~fill_word(a_d);
            end
            S_RANDOM: begin
                nx_busy   = 1'b1;
                nx_we     = lfsr_q[0];
                nx_re     = lfsr_q[1];
                nx_wclke  = lfsr_q[2];
                nx_addren = lfsr_q[3];
                nx_byteen = lfsr_q[4 +: BYTEEN_WIDTH];
                nx_addr   = lfsr_q[12 +: ADDR_WIDTH_A];
                nx_wdata  = rand_word(lfsr_q[31:16]);
            end
            S_RSTP: begin
                nx_busy     = 1'b1;
                nx_bram_rst = 1'b1;
                nx_re       = 1'b1;
                nx_addren   = 1'b1;
            end
            S_DRAIN: begin
                // Idle stimulus while the checker's output pipeline flushes.
                nx_busy = 1'b1;
            end
            S_DONE: begin
                nx_done = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters, LFSR and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            acnt_q   <= '0;
            ocnt_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            busy     <= 1'b0;
            done     <= 1'b0;
            bram_rst <= 1'b0 ~^ RST_POLARITY;
            wclke    <= 1'b0 ~^ WCLKE_POLARITY;
            we       <= 1'b0 ~^ WE_POLARITY;
            re       <= 1'b0 ~^ RE_POLARITY;
            addren   <= IS_TRION ? ADDREN_POLARITY : (1'b0 ~^ ADDREN_POLARITY);
            addr     <= '0;
            byteen   <= {BYTEEN_WIDTH{1'b0 ~^ BYTEEN_POLARITY}};
            wdata_a  <= '0;
        end else begin
            state_q  <= state_d;
            acnt_q   <= acnt_d;
            ocnt_q   <= ocnt_d;
            lfsr_q   <= lfsr_d;
            busy     <= nx_busy;
            done     <= nx_done;
            bram_rst <= nx_bram_rst ~^ RST_POLARITY;
            wclke    <= nx_wclke ~^ WCLKE_POLARITY;
            we       <= nx_we ~^ WE_POLARITY;
            re       <= nx_re ~^ RE_POLARITY;
            addren   <= IS_TRION ? ADDREN_POLARITY : (nx_addren ~^ ADDREN_POLARITY);
            addr     <= nx_addr;
            byteen   <= nx_byteen ~^ {BYTEEN_WIDTH{BYTEEN_POLARITY}};
            wdata_a  <= nx_wdata;
        end
    end

endmodule
